mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sits directly downstream of the CPU memory ports (icache_*/dcache_* and instruction) and merges them onto one single-ported, variable-latency backing-memory request/response channel.
- Captures each cycle's requests and asserts stall while it serialises them. Returns read data on instruction/dcache_dout with the CPU's one-cycle block-RAM timing once stall drops.

Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports
- WE_W, 4, byte-write-enable width (DATA_W/8)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- icache_addr  input  ADDR_W  instruction-side address
- icache_re  input  1  instruction read request
- icache_we  input  WE_W  instruction-side byte write enables (imem self-modify)
- icache_din  input  DATA_W  instruction-side write data
- instruction  output  DATA_W  last instruction-side read data
- dcache_addr  input  ADDR_W  data-side address
- dcache_re  input  1  data read request
- dcache_we  input  WE_W  data-side byte write enables
- dcache_din  input  DATA_W  data-side write data
- dcache_dout  output  DATA_W  last data-side read data
- stall  output  1  CPU stall, high while requests are pending
- mem_req_valid  output  1  backing-memory request valid
- mem_req_ready  input  1  backing memory accepts request
- mem_req_addr  output  ADDR_W  request address, word aligned ([1:0]=0)
- mem_req_we  output  WE_W  0 = read, nonzero = byte-masked write
- mem_req_data  output  DATA_W  write data
- mem_resp_valid  input  1  read data valid, one pulse per read
- mem_resp_data  input  DATA_W  read data

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pending slots cleared.
  - stall=0, mem_req_valid=0, mem_req_addr/we/data=0.
  - instruction=0, dcache_dout=0.
- Reset mid-transaction abandons it; a response arriving later is ignored.
- Capture: only in IDLE, on a rising edge, when a request input is active. Three slots are captured from the ports:
  - D: dcache_we≠0 gives a write (dcache_re ignored); else dcache_re gives a read.
  - IW: icache_we≠0.
  - IR: icache_re.
- Capture with no slot active: stay IDLE, outputs unchanged.
- Service order is fixed: D, then IW, then IR. Empty slots are skipped with zero cycles spent.
- States: IDLE, ISSUE, WAIT_RESP.
  - ISSUE: mem_req_valid=1 with the current slot's payload.
  - Payload stays stable while valid=1 and ready=0.
  - On valid&ready: a write advances to the next slot (or IDLE); a read goes to WAIT_RESP.
- mem_resp_valid is sampled only in WAIT_RESP. The backing memory guarantees at least 1 cycle between accept and response.
  - On response: D read loads dcache_dout; IR loads instruction.
  - Then advance to the next slot, or IDLE.
- stall is registered: stall = (state≠IDLE). It rises the cycle after capture and falls the cycle the final slot completes.
  - Data outputs update on the same edge that returns to IDLE, so the CPU sees valid data in the first cycle with stall=0.
- Minimum latency for a single read with 1-cycle memory: capture edge, then accept edge, then response edge. stall is high for exactly 2 cycles.
- Outputs not reloaded by a sequence hold their previous value.
- IW and D to the same address: D completes first; no merging or forwarding.
- mem_req_addr = captured address with bits [1:0] forced to 0.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles (32) and mem_reads (32), both reset to 0.
  - stall_cycles increments every cycle stall=1.
  - mem_reads increments on each accepted read request.
  - Both wrap from 0xFFFFFFFF to 0 silently.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then icache_re=1, icache_addr=0x40000010, memory ready=1, 1-cycle response 0x00000013:
  - mem_req_addr=0x40000010, we=0.
  - stall high 2 cycles, then instruction=0x00000013 with stall=0.
- dcache_we=4'b0011, dcache_addr=0x10000006, dcache_din=0xAABBCCDD, plus icache_re:
  - first request addr=0x10000004, we=0011, data 0xAABBCCDD, no response wait.
  - then the IR read; instruction updated; dcache_dout unchanged.
- Hold mem_req_ready=0 for 5 cycles during D read 0x100 (response 0xDEADBEEF):
  - addr/we/data stable throughout.
  - stall stays high; dcache_dout=0xDEADBEEF after completion.
- dcache_re + icache_we=4'hF + icache_re simultaneously:
  - requests issued D-read, IW-write, IR-read in that order; exactly three handshakes.
- Assert rst=0 during WAIT_RESP:
  - stall and mem_req_valid drop immediately (asynchronous).
  - A late mem_resp_valid after release leaves dcache_dout=0 and instruction=0.
- With MEM_ARB_PERF_CNT_EN, run the first scenario twice: stall_cycles=4, mem_reads=2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Merges the CPU icache/dcache ports onto one single-ported, variable-latency
// memory channel. Optional performance counters are enabled by MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WE_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              icache_re,
    input  logic [WE_W-1:0]   icache_we,
    input  logic [DATA_W-1:0] icache_din,
    output logic [DATA_W-1:0] instruction,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_re,
    input  logic [WE_W-1:0]   dcache_we,
    input  logic [DATA_W-1:0] dcache_din,
    output logic [DATA_W-1:0] dcache_dout,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [WE_W-1:0]   mem_req_we,
    output logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       mem_reads
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2
    } state_e;

    // Slot order doubles as service priority: D, then IW, then IR.
    typedef enum logic [1:0] {
        SLOT_D  = 2'd0,
        SLOT_IW = 2'd1,
        SLOT_IR = 2'd2
    } slot_e;

    function automatic slot_e first_slot(input logic [2:0] pend);
        slot_e s;
        if (pend[0]) begin
            s = SLOT_D;
        end else if (pend[1]) begin
            s = SLOT_IW;
        end else begin
            s = SLOT_IR;
        end
        return s;
    endfunction

    function automatic logic [2:0] slot_bit(input slot_e s);
        logic [2:0] b;
        case (s)
            SLOT_D:  b = 3'b001;
            SLOT_IW: b = 3'b010;
            SLOT_IR: b = 3'b100;
            default: b = 3'b000;
        endcase
        return b;
    endfunction

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & {{(ADDR_W-2){1'b1}}, 2'b00};
    endfunction

    state_e             state_q, state_d;
    slot_e              slot_q, slot_d;
    logic [2:0]         pend_q, pend_d;
    logic               d_write_q, d_write_d;
    logic [ADDR_W-1:0]  d_addr_q, d_addr_d;
    logic [WE_W-1:0]    d_we_q, d_we_d;
    logic [DATA_W-1:0]  d_data_q, d_data_d;
    logic [ADDR_W-1:0]  iw_addr_q, iw_addr_d;
    logic [WE_W-1:0]    iw_we_q, iw_we_d;
    logic [DATA_W-1:0]  iw_data_q, iw_data_d;
    logic [ADDR_W-1:0]  ir_addr_q, ir_addr_d;
    logic               stall_q, stall_d;
    logic               req_valid_q, req_valid_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [WE_W-1:0]    req_we_q, req_we_d;
    logic [DATA_W-1:0]  req_data_q, req_data_d;
    logic [DATA_W-1:0]  instr_q, instr_d;
    logic [DATA_W-1:0]  dout_q, dout_d;

    logic [2:0]         cap_pend_s;
    logic [2:0]         pend_left_s;
    logic               cur_is_write_s;

    assign cap_pend_s  = {icache_re, (|icache_we), ((|dcache_we) | dcache_re)};
    assign pend_left_s = pend_q & ~slot_bit(slot_q);

    // Decode whether the slot currently being serviced is a write.
    always_comb begin
        cur_is_write_s = 1'b0;
        case (slot_q)
            SLOT_D:  cur_is_write_s = d_write_q;
            SLOT_IW: cur_is_write_s = 1'b1;
            SLOT_IR: cur_is_write_s = 1'b0;
            default: cur_is_write_s = 1'b0;
        endcase
    end

    // Next-state, slot capture, response return and request payload.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        pend_d     = pend_q;
        d_write_d  = d_write_q;
        d_addr_d   = d_addr_q;
        d_we_d     = d_we_q;
        d_data_d   = d_data_q;
        iw_addr_d  = iw_addr_q;
        iw_we_d    = iw_we_q;
        iw_data_d  = iw_data_q;
        ir_addr_d  = ir_addr_q;
        instr_d    = instr_q;
        dout_d     = dout_q;
        req_addr_d = req_addr_q;
        req_we_d   = req_we_q;
        req_data_d = req_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cap_pend_s != 3'b000) begin
                    d_write_d = |dcache_we;
                    d_addr_d  = word_align(dcache_addr);
                    d_we_d    = dcache_we;
                    d_data_d  = dcache_din;
                    iw_addr_d = word_align(icache_addr);
                    iw_we_d   = icache_we;
                    iw_data_d = icache_din;
                    ir_addr_d = word_align(icache_addr);
                    pend_d    = cap_pend_s;
                    slot_d    = first_slot(cap_pend_s);
                    state_d   = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    if (cur_is_write_s) begin
                        pend_d = pend_left_s;
                        if (pend_left_s != 3'b000) begin
                            slot_d  = first_slot(pend_left_s);
                            state_d = ST_ISSUE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_WAIT_RESP;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_RESP: begin
                if (mem_resp_valid) begin
                    if (slot_q == SLOT_D) begin
                        dout_d = mem_resp_data;
                    end else if (slot_q == SLOT_IR) begin
                        instr_d = mem_resp_data;
                    end else begin
                        dout_d = dout_q;
                    end
                    pend_d = pend_left_s;
                    if (pend_left_s != 3'b000) begin
                        slot_d  = first_slot(pend_left_s);
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WAIT_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 3'b000;
            end
        endcase

        // Payload is reloaded only when (re)entering ISSUE, so it holds while stalled.
        if (state_d == ST_ISSUE) begin
            case (slot_d)
                SLOT_D: begin
                    req_addr_d = d_addr_d;
                    req_we_d   = d_write_d ? d_we_d : {WE_W{1'b0}};
                    req_data_d = d_data_d;
                end
                SLOT_IW: begin
                    req_addr_d = iw_addr_d;
                    req_we_d   = iw_we_d;
                    req_data_d = iw_data_d;
                end
                SLOT_IR: begin
                    req_addr_d = ir_addr_d;
                    req_we_d   = {WE_W{1'b0}};
                    req_data_d = {DATA_W{1'b0}};
                end
                default: begin
                    req_addr_d = {ADDR_W{1'b0}};
                    req_we_d   = {WE_W{1'b0}};
                    req_data_d = {DATA_W{1'b0}};
                end
            endcase
        end else begin
            req_addr_d = req_addr_q;
            req_we_d   = req_we_q;
            req_data_d = req_data_q;
        end

        req_valid_d = (state_d == ST_ISSUE);
        stall_d     = (state_d != ST_IDLE);
    end

    // State, slot storage and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            slot_q      <= SLOT_D;
            pend_q      <= 3'b000;
            d_write_q   <= 1'b0;
            d_addr_q    <= {ADDR_W{1'b0}};
            d_we_q      <= {WE_W{1'b0}};
            d_data_q    <= {DATA_W{1'b0}};
            iw_addr_q   <= {ADDR_W{1'b0}};
            iw_we_q     <= {WE_W{1'b0}};
            iw_data_q   <= {DATA_W{1'b0}};
            ir_addr_q   <= {ADDR_W{1'b0}};
            stall_q     <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= {ADDR_W{1'b0}};
            req_we_q    <= {WE_W{1'b0}};
            req_data_q  <= {DATA_W{1'b0}};
            instr_q     <= {DATA_W{1'b0}};
            dout_q      <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            pend_q      <= pend_d;
            d_write_q   <= d_write_d;
            d_addr_q    <= d_addr_d;
            d_we_q      <= d_we_d;
            d_data_q    <= d_data_d;
            iw_addr_q   <= iw_addr_d;
            iw_we_q     <= iw_we_d;
            iw_data_q   <= iw_data_d;
            ir_addr_q   <= ir_addr_d;
            stall_q     <= stall_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_we_q    <= req_we_d;
            req_data_q  <= req_data_d;
            instr_q     <= instr_d;
            dout_q      <= dout_d;
        end
    end

    assign stall         = stall_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_we    = req_we_q;
    assign mem_req_data  = req_data_q;
    assign instruction   = instr_q;
    assign dcache_dout   = dout_q;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] mem_reads_q;
    logic        read_accept_s;

    assign read_accept_s = (state_q == ST_ISSUE) && mem_req_ready && !cur_is_write_s;

    // Free-running counters; wrap silently at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= 32'd0;
            mem_reads_q    <= 32'd0;
        end else begin
            if (stall_q) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end else begin
                stall_cycles_q <= stall_cycles_q;
            end
            if (read_accept_s) begin
                mem_reads_q <= mem_reads_q + 32'd1;
            end else begin
                mem_reads_q <= mem_reads_q;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign mem_reads    = mem_reads_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change and outputs
// are sampled on the falling clock edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [3:0]  icache_we;
    logic [31:0] icache_din;
    logic [31:0] instruction;
    logic [31:0] dcache_addr;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_we;
    logic [31:0] mem_req_data;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] mem_reads;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] hs_addr[$];
    logic [3:0]  hs_we[$];
    logic [31:0] hs_data[$];
    int          stall_cnt;
    logic        timeout_f;
    logic        stable_f;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WE_W(4)) dut (
        .clk(clk), .rst(rst),
        .icache_addr(icache_addr), .icache_re(icache_re), .icache_we(icache_we),
        .icache_din(icache_din), .instruction(instruction),
        .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
        .dcache_din(dcache_din), .dcache_dout(dcache_dout),
        .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef MEM_ARB_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .mem_reads(mem_reads)
`endif
    );

    task automatic clear_cpu;
        icache_addr = 32'h0; icache_re = 1'b0; icache_we = 4'h0; icache_din = 32'h0;
        dcache_addr = 32'h0; dcache_re = 1'b0; dcache_we = 4'h0; dcache_din = 32'h0;
    endtask

    // Memory responder: starts just after the capture edge, ends when stall drops.
    task automatic run_mem(input int hold, input logic [31:0] r0, input logic [31:0] r1);
        int          held = 0;
        int          ridx = 0;
        logic        resp_next = 1'b0;
        logic [31:0] a0 = 32'h0;
        logic [3:0]  w0 = 4'h0;
        logic [31:0] d0 = 32'h0;
        hs_addr.delete(); hs_we.delete(); hs_data.delete();
        stall_cnt = 0; timeout_f = 1'b1; stable_f = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (cyc == 0) clear_cpu();
            mem_resp_valid = 1'b0;
            if (resp_next) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = (ridx == 0) ? r0 : r1;
                ridx++;
                resp_next = 1'b0;
            end
            if (!stall) begin
                timeout_f = 1'b0;
                mem_req_ready = 1'b0;
                break;
            end
            stall_cnt++;
            if (mem_req_valid) begin
                if (held == 0) begin
                    a0 = mem_req_addr; w0 = mem_req_we; d0 = mem_req_data;
                end else if (mem_req_addr !== a0 || mem_req_we !== w0 || mem_req_data !== d0) begin
                    stable_f = 1'b0;
                end
                if (held < hold) begin
                    mem_req_ready = 1'b0;
                    held++;
                end else begin
                    mem_req_ready = 1'b1;
                    hs_addr.push_back(mem_req_addr);
                    hs_we.push_back(mem_req_we);
                    hs_data.push_back(mem_req_data);
                    if (mem_req_we == 4'h0) resp_next = 1'b1;
                    held = 0;
                end
            end else begin
                mem_req_ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        clear_cpu();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({stall, mem_req_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ctrl: stall/valid got %b want 00", {stall, mem_req_valid});
        end
        vectors++;
        if ({mem_req_addr, mem_req_we, mem_req_data} !== 68'h0) begin
            miscompares++;
            $display("FAIL reset_req: addr %h we %h data %h want 0", mem_req_addr, mem_req_we, mem_req_data);
        end
        vectors++;
        if ({instruction, dcache_dout} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_data: instr %h dout %h want 0", instruction, dcache_dout);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({stall, mem_req_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_no_req: stall/valid got %b want 00", {stall, mem_req_valid});
        end
    endtask

    task automatic test_single_read;
        icache_re = 1'b1; icache_addr = 32'h4000_0010;
        run_mem(0, 32'h0000_0013, 32'h0);
        vectors++;
        if (timeout_f !== 1'b0 || hs_addr.size() != 1) begin
            miscompares++;
            $display("FAIL rd_handshakes: timeout %b count %0d want 0/1", timeout_f, hs_addr.size());
        end else begin
            vectors++;
            if (hs_addr[0] !== 32'h4000_0010 || hs_we[0] !== 4'h0) begin
                miscompares++;
                $display("FAIL rd_req: addr %h we %h want 40000010/0", hs_addr[0], hs_we[0]);
            end
        end
        vectors++;
        if (stall_cnt != 2) begin
            miscompares++;
            $display("FAIL rd_stall_len: got %0d want 2", stall_cnt);
        end
        vectors++;
        if (instruction !== 32'h0000_0013 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_instr: instr %h stall %b want 00000013/0", instruction, stall);
        end
    endtask

    task automatic test_write_then_read;
        dcache_we = 4'b0011; dcache_re = 1'b1; dcache_addr = 32'h1000_0006; dcache_din = 32'hAABB_CCDD;
        icache_re = 1'b1; icache_addr = 32'h4000_0020;
        run_mem(0, 32'h00A0_0093, 32'h0);
        vectors++;
        if (timeout_f !== 1'b0 || hs_addr.size() != 2) begin
            miscompares++;
            $display("FAIL wr_handshakes: timeout %b count %0d want 0/2", timeout_f, hs_addr.size());
        end else begin
            vectors++;
            if (hs_addr[0] !== 32'h1000_0004 || hs_we[0] !== 4'b0011 || hs_data[0] !== 32'hAABB_CCDD) begin
                miscompares++;
                $display("FAIL wr_req: addr %h we %h data %h want 10000004/3/aabbccdd", hs_addr[0], hs_we[0], hs_data[0]);
            end
            vectors++;
            if (hs_addr[1] !== 32'h4000_0020 || hs_we[1] !== 4'h0) begin
                miscompares++;
                $display("FAIL wr_ir_req: addr %h we %h want 40000020/0", hs_addr[1], hs_we[1]);
            end
        end
        vectors++;
        if (stall_cnt != 3) begin
            miscompares++;
            $display("FAIL wr_stall_len: got %0d want 3", stall_cnt);
        end
        vectors++;
        if (instruction !== 32'h00A0_0093 || dcache_dout !== 32'h0) begin
            miscompares++;
            $display("FAIL wr_outputs: instr %h dout %h want 00a00093/0", instruction, dcache_dout);
        end
    endtask

    task automatic test_backpressure;
        dcache_re = 1'b1; dcache_addr = 32'h0000_0100;
        run_mem(5, 32'hDEAD_BEEF, 32'h0);
        vectors++;
        if (timeout_f !== 1'b0 || hs_addr.size() != 1 || stable_f !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_stable: timeout %b count %0d stable %b want 0/1/1", timeout_f, hs_addr.size(), stable_f);
        end else begin
            vectors++;
            if (hs_addr[0] !== 32'h0000_0100 || hs_we[0] !== 4'h0) begin
                miscompares++;
                $display("FAIL bp_req: addr %h we %h want 00000100/0", hs_addr[0], hs_we[0]);
            end
        end
        vectors++;
        if (stall_cnt != 7) begin
            miscompares++;
            $display("FAIL bp_stall_len: got %0d want 7", stall_cnt);
        end
        vectors++;
        if (dcache_dout !== 32'hDEAD_BEEF || instruction !== 32'h00A0_0093) begin
            miscompares++;
            $display("FAIL bp_outputs: dout %h instr %h want deadbeef/00a00093", dcache_dout, instruction);
        end
    endtask

    task automatic test_three_slots;
        logic [31:0] exp_a[3];
        logic [3:0]  exp_w[3];
        exp_a[0] = 32'h0000_0200; exp_w[0] = 4'h0;
        exp_a[1] = 32'h0000_0300; exp_w[1] = 4'hF;
        exp_a[2] = 32'h0000_0300; exp_w[2] = 4'h0;
        dcache_re = 1'b1; dcache_addr = 32'h0000_0200;
        icache_we = 4'hF; icache_re = 1'b1; icache_addr = 32'h0000_0300; icache_din = 32'h1234_5678;
        run_mem(0, 32'h1111_1111, 32'h2222_2222);
        vectors++;
        if (timeout_f !== 1'b0 || hs_addr.size() != 3) begin
            miscompares++;
            $display("FAIL ord_count: timeout %b count %0d want 0/3", timeout_f, hs_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (hs_addr[i] !== exp_a[i] || hs_we[i] !== exp_w[i]) begin
                    miscompares++;
                    $display("FAIL ord_req%0d: addr %h we %h want %h/%h", i, hs_addr[i], hs_we[i], exp_a[i], exp_w[i]);
                end
            end
            vectors++;
            if (hs_data[1] !== 32'h1234_5678) begin
                miscompares++;
                $display("FAIL ord_iw_data: got %h want 12345678", hs_data[1]);
            end
        end
        vectors++;
        if (stall_cnt != 5) begin
            miscompares++;
            $display("FAIL ord_stall_len: got %0d want 5", stall_cnt);
        end
        vectors++;
        if (dcache_dout !== 32'h1111_1111 || instruction !== 32'h2222_2222) begin
            miscompares++;
            $display("FAIL ord_outputs: dout %h instr %h want 11111111/22222222", dcache_dout, instruction);
        end
    endtask

    task automatic test_reset_mid;
        // Reset while a read is waiting for its response.
        dcache_re = 1'b1; dcache_addr = 32'h0000_0100; mem_req_ready = 1'b1;
        @(negedge clk);
        clear_cpu();
        @(negedge clk);
        mem_req_ready = 1'b0;
        vectors++;
        if ({stall, mem_req_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL rm_wait: stall/valid got %b want 10", {stall, mem_req_valid});
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({stall, mem_req_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL rm_async_wait: stall/valid got %b want 00", {stall, mem_req_valid});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (dcache_dout !== 32'h0 || instruction !== 32'h0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL rm_late_resp: dout %h instr %h stall %b want 0/0/0", dcache_dout, instruction, stall);
        end
        // Reset while a request is held off by the memory.
        icache_re = 1'b1; icache_addr = 32'h0000_0040;
        @(negedge clk);
        clear_cpu();
        @(negedge clk);
        vectors++;
        if ({stall, mem_req_valid} !== 2'b11) begin
            miscompares++;
            $display("FAIL rm_issue: stall/valid got %b want 11", {stall, mem_req_valid});
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({stall, mem_req_valid, mem_req_addr} !== 34'h0) begin
            miscompares++;
            $display("FAIL rm_async_issue: stall %b valid %b addr %h want 0/0/0", stall, mem_req_valid, mem_req_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

`ifdef MEM_ARB_PERF_CNT_EN
    task automatic test_perf;
        test_reset();
        for (int k = 0; k < 2; k++) begin
            icache_re = 1'b1; icache_addr = 32'h4000_0010;
            run_mem(0, 32'h0000_0013, 32'h0);
        end
        vectors++;
        if (stall_cycles !== 32'd4 || mem_reads !== 32'd2) begin
            miscompares++;
            $display("FAIL perf: stall_cycles %0d mem_reads %0d want 4/2", stall_cycles, mem_reads);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_write_then_read();
        test_backpressure();
        test_three_slots();
        test_reset_mid();
`ifdef MEM_ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
